max_product_bwd: RTL and testbench
==================================

Name: max_product_bwd

Overview:
- Synthesizable fixed-point successor to the real-valued, single-call max-product (max-log-MAP) backward pass of the BCJR decoder.
- Buffers one frame of per-section branch metrics and forward (alpha) metrics, then runs the beta recursion one trellis section per cycle with all states in parallel.
- Streams per-code-bit LLRs out in reverse section order.
- Sits after the alpha/forward unit and before the extrinsic/interleaver stage of the turbo loop.

Parameters:
- MEMORY, 3, encoder memory; STATES = 2**MEMORY
- FB_POLY, 4'b1011, RSC feedback taps [MEMORY:0]; bit MEMORY is the input tap
- FF_POLY, 4'b1101, RSC parity taps [MEMORY:0]
- METRIC_W, 12, signed width of branch, alpha and beta metrics
- LLR_W, 10, signed output LLR width
- MAX_SYMBOLS, 64, frame buffer depth in sections
- TERMINATED, 1, 1 means beta init is state 0 = 0 and others NEG_INF; 0 means all states 0

Ports:
- clk in 1: clock
- rst_n in 1: asynchronous active-low reset
- in_valid in 1: section input valid
- in_ready out 1: block accepts a section
- in_last in 1: final section of frame
- in_bm in 4*METRIC_W: branch metric per output symbol {u,p}; index 0 in LSBs
- in_alpha in STATES*METRIC_W: alpha at section start, per state
- out_valid out 1: LLR valid
- out_ready in 1: downstream accepts
- out_llr out 2*LLR_W: [LLR_W-1:0] = u-bit LLR, upper half = p-bit LLR
- out_index out $clog2(MAX_SYMBOLS): section index of out_llr
- out_last out 1: marks section 0, the final output
- overflow out 1: sticky; frame exceeded MAX_SYMBOLS

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_llr=0, out_index=0, out_last=0, overflow=0, FSM=IDLE.
- rst_n is asynchronous and active-low. Asserting it mid-frame aborts the frame; buffer contents become don't-care.
- Trellis, for state s and input u:
  - a = u ^ ^(s & FB_POLY[MEMORY-1:0])
  - p = (FF_POLY[MEMORY] & a) ^ ^(s & FF_POLY[MEMORY-1:0])
  - next = {s[MEMORY-2:0], a}
  - output symbol = {u,p}, with u as MSB
- Arithmetic:
  - All adds saturate to [NEG_INF, +2**(METRIC_W-1)-1], where NEG_INF = -(2**(METRIC_W-1)-1).
  - Any operand equal to NEG_INF forces the sum to NEG_INF.
- FSM:
  - IDLE -> LOAD on the cycle after reset release; in_ready=1.
  - LOAD: each in_valid&in_ready writes {in_bm, in_alpha} at wr_ptr and increments wr_ptr.
    - in_last, or the write at address MAX_SYMBOLS-1, ends the load: FSM -> RUN, in_ready=0, N = wr_ptr+1.
    - If the capacity write lacks in_last, set overflow, treat that write as last, and drop further input until the in_last beat.
  - RUN: k counts down from N-1 to 0.
    - Beta is initialised per TERMINATED on entry.
    - Per section k, for each state s and each u:
      - cur = beta[next] + bm[k][{u,p}]
      - beta_new[s] = max over u of cur
      - om = cur + alpha[k][s]
    - max1/max0 for each bit are the maxima of om over branches with that bit 1/0.
    - LLR = max1 - max0, saturated to LLR_W; NEG_INF - x gives -(2**(LLR_W-1)-1).
    - Normalise: beta <= beta_new - max_s(beta_new), with NEG_INF entries kept at NEG_INF.
    - The result registers to out_* one cycle after section k is read (latency 1).
    - Stall: while out_valid & !out_ready, k, beta and out_* hold.
  - RUN -> LOAD after the section-0 output handshakes; wr_ptr=0, in_ready=1 the next cycle.
- Throughput: one section per cycle with no backpressure.
- overflow clears only on reset.

Test Plan:
- TERMINATED=0, N=1, bm[0]=10, bm[3]=6, bm[1]=bm[2]=0, alpha all 0 -> one output: out_llr u=-4, p=-4; out_index=0; out_last=1.
- TERMINATED=1, N=1, bm[0]=10, others 0, alpha 0 -> u-LLR=-(2**(LLR_W-1)-1), p-LLR=-10 (branches into state 0 are only 0->0 sym 00 and 4->0 sym 01).
- N=4, random metrics within ±200, out_ready=1 -> out_index 3,2,1,0 on consecutive cycles starting one cycle after the last input, out_last on index 0; values bit-exact to a saturating integer model.
- Same frame with out_ready toggling 1,0,0,1 -> identical values; out_* held stable during stalls; no index skipped or duplicated.
- MAX_SYMBOLS+2 sections with in_last on the final beat -> overflow=1, exactly MAX_SYMBOLS outputs, then in_ready=1 for the next frame.
- rst_n pulsed low in mid-RUN -> out_valid=0 immediately; a fresh 2-section frame then decodes correctly.

Source files
------------

// File: rtl/max_product_bwd.sv
// Max-log-MAP backward (beta) unit: buffers one frame of branch/alpha metrics,
// then runs the beta recursion one section per cycle and streams LLRs in reverse.
module max_product_bwd #(
  parameter int              MEMORY      = 3,
  parameter logic [MEMORY:0] FB_POLY     = 4'b1011,
  parameter logic [MEMORY:0] FF_POLY     = 4'b1101,
  parameter int              METRIC_W    = 12,
  parameter int              LLR_W       = 10,
  parameter int              MAX_SYMBOLS = 64,
  parameter int              TERMINATED  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_last,
  input  logic [4*METRIC_W-1:0]                in_bm,
  input  logic [(2**MEMORY)*METRIC_W-1:0]      in_alpha,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [2*LLR_W-1:0]                   out_llr,
  output logic [$clog2(MAX_SYMBOLS)-1:0]       out_index,
  output logic                                 out_last,
  output logic                                 overflow
);
  localparam int STATES = 2**MEMORY;
  localparam int AW     = $clog2(MAX_SYMBOLS);
  localparam logic signed [METRIC_W-1:0] POS_MAX = METRIC_W'(2**(METRIC_W-1)-1);
  localparam logic signed [METRIC_W-1:0] NEG_INF = -POS_MAX;
  localparam logic signed [METRIC_W:0]   POS_X   = (METRIC_W+1)'(2**(METRIC_W-1)-1);
  localparam logic signed [METRIC_W:0]   NEG_X   = -POS_X;
  localparam logic signed [LLR_W-1:0]    LLR_MAX = LLR_W'(2**(LLR_W-1)-1);
  localparam logic signed [LLR_W-1:0]    LLR_MIN = -LLR_MAX;
  localparam logic signed [METRIC_W:0]   LMAX_X  = (METRIC_W+1)'(2**(LLR_W-1)-1);

  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, RUN = 2'd3;

  function automatic logic signed [METRIC_W-1:0] clamp(input logic signed [METRIC_W:0] s);
    if (s > POS_X) return POS_MAX;
    if (s < NEG_X) return NEG_INF;
    return s[METRIC_W-1:0];
  endfunction

  function automatic logic signed [METRIC_W-1:0] sadd(input logic signed [METRIC_W-1:0] a,
                                                      input logic signed [METRIC_W-1:0] b);
    if (a == NEG_INF || b == NEG_INF) return NEG_INF;
    return clamp((METRIC_W+1)'(a) + (METRIC_W+1)'(b));
  endfunction

  function automatic logic signed [METRIC_W-1:0] ssub(input logic signed [METRIC_W-1:0] a,
                                                      input logic signed [METRIC_W-1:0] b);
    return clamp((METRIC_W+1)'(a) - (METRIC_W+1)'(b));
  endfunction

  // An unreachable bit value (all its branches NEG_INF) pins the LLR to the rail.
  function automatic logic signed [LLR_W-1:0] llr(input logic signed [METRIC_W-1:0] m1,
                                                  input logic signed [METRIC_W-1:0] m0);
    logic signed [METRIC_W:0] d;
    d = (METRIC_W+1)'(m1) - (METRIC_W+1)'(m0);
    if (m1 == NEG_INF) return LLR_MIN;
    if (m0 == NEG_INF) return LLR_MAX;
    if (d > LMAX_X)    return LLR_MAX;
    if (d < -LMAX_X)   return LLR_MIN;
    return d[LLR_W-1:0];
  endfunction

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr, k;
  logic          issuing, adv;

  logic [4*METRIC_W-1:0]      bm_mem [MAX_SYMBOLS];
  logic [STATES*METRIC_W-1:0] al_mem [MAX_SYMBOLS];

  logic signed [METRIC_W-1:0] bm_k [4];
  logic signed [METRIC_W-1:0] alpha_k [STATES];
  logic signed [METRIC_W-1:0] beta [STATES];
  logic signed [METRIC_W-1:0] beta_new [STATES];
  logic signed [METRIC_W-1:0] beta_nrm [STATES];
  logic signed [METRIC_W-1:0] cur [STATES][2];
  logic signed [METRIC_W-1:0] om [STATES][2];
  logic                       p_bit [STATES][2];
  logic signed [METRIC_W-1:0] m1u, m0u, m1p, m0p, bmax;

  assign in_ready = (state == LOAD) || (state == DRAIN);
  assign adv      = (state == RUN) && issuing && !(out_valid && !out_ready);

  always_ff @(posedge clk)
    if (state == LOAD && in_valid) begin
      bm_mem[wr_ptr] <= in_bm;
      al_mem[wr_ptr] <= in_alpha;
    end

  always_comb begin
    for (int i = 0; i < 4; i++)      bm_k[i]    = bm_mem[k][i*METRIC_W +: METRIC_W];
    for (int s = 0; s < STATES; s++) alpha_k[s] = al_mem[k][s*METRIC_W +: METRIC_W];
  end

  // Trellis wiring is fixed at elaboration: one branch pair per state.
  for (genvar gs = 0; gs < STATES; gs++) begin : g_st
    for (genvar gu = 0; gu < 2; gu++) begin : g_u
      localparam logic [MEMORY-1:0] SV = MEMORY'(gs);
      localparam logic A   = 1'(gu) ^ (^(SV & FB_POLY[MEMORY-1:0]));
      localparam logic P   = (FF_POLY[MEMORY] & A) ^ (^(SV & FF_POLY[MEMORY-1:0]));
      localparam int   NXT = int'({SV[MEMORY-2:0], A});
      localparam int   SYM = 2*gu + int'(P);
      assign cur[gs][gu]   = sadd(beta[NXT], bm_k[SYM]);
      assign om[gs][gu]    = sadd(cur[gs][gu], alpha_k[gs]);
      assign p_bit[gs][gu] = P;
    end
  end

  always_comb begin
    m1u = NEG_INF; m0u = NEG_INF; m1p = NEG_INF; m0p = NEG_INF; bmax = NEG_INF;
    for (int s = 0; s < STATES; s++) begin
      beta_new[s] = (cur[s][1] > cur[s][0]) ? cur[s][1] : cur[s][0];
      if (beta_new[s] > bmax) bmax = beta_new[s];
      for (int u = 0; u < 2; u++) begin
        if (u == 1) begin if (om[s][u] > m1u) m1u = om[s][u]; end
        else        begin if (om[s][u] > m0u) m0u = om[s][u]; end
        if (p_bit[s][u]) begin if (om[s][u] > m1p) m1p = om[s][u]; end
        else             begin if (om[s][u] > m0p) m0p = om[s][u]; end
      end
    end
    for (int s = 0; s < STATES; s++)
      beta_nrm[s] = (beta_new[s] == NEG_INF) ? NEG_INF : ssub(beta_new[s], bmax);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      issuing   <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_llr   <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      for (int s = 0; s < STATES; s++) beta[s] <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= LOAD;
          wr_ptr <= '0;
        end
        LOAD: if (in_valid) begin
          if (in_last || wr_ptr == AW'(MAX_SYMBOLS-1)) begin
            k       <= wr_ptr;
            issuing <= 1'b1;
            for (int s = 0; s < STATES; s++)
              beta[s] <= (TERMINATED != 0 && s != 0) ? NEG_INF : '0;
            if (in_last) state <= RUN;
            else begin
              state    <= DRAIN;
              overflow <= 1'b1;
            end
          end else wr_ptr <= wr_ptr + 1'b1;
        end
        DRAIN: if (in_valid && in_last) state <= RUN;
        default: if (out_valid && out_ready && out_last) begin
          state  <= LOAD;
          wr_ptr <= '0;
        end
      endcase

      if (adv) begin
        out_valid <= 1'b1;
        out_llr   <= {llr(m1p, m0p), llr(m1u, m0u)};
        out_index <= k;
        out_last  <= (k == '0);
        for (int s = 0; s < STATES; s++) beta[s] <= beta_nrm[s];
        if (k == '0) issuing <= 1'b0;
        else         k <= k - 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_max_product_bwd.sv
// Scoreboard bench: a terminated and an open-start instance share stimulus and are
// checked against a saturating integer model of the beta recursion.
module tb_max_product_bwd;
  localparam int MW = 12, LW = 10, MS = 64, ST = 8;
  localparam int NEG = -2047, POS = 2047, LM = 511;
  localparam int FBM = 4'b1011 & 7, FFM = 4'b1101 & 7, FFTOP = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [4*MW-1:0]  in_bm = '0;
  logic [ST*MW-1:0] in_alpha = '0;
  logic in_ready_t, out_valid_t, out_last_t, overflow_t;
  logic in_ready_o, out_valid_o, out_last_o, overflow_o;
  logic [2*LW-1:0] out_llr_t, out_llr_o;
  logic [5:0] out_index_t, out_index_o;

  max_product_bwd #(.TERMINATED(1)) dut_trm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t), .in_last(in_last),
    .in_bm(in_bm), .in_alpha(in_alpha), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_llr(out_llr_t), .out_index(out_index_t), .out_last(out_last_t), .overflow(overflow_t));

  max_product_bwd #(.TERMINATED(0)) dut_opn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o), .in_last(in_last),
    .in_bm(in_bm), .in_alpha(in_alpha), .out_valid(out_valid_o), .out_ready(out_ready),
    .out_llr(out_llr_o), .out_index(out_index_o), .out_last(out_last_o), .overflow(overflow_o));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [19:0] lt; logic [19:0] lo; logic last; } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0, last_in_cyc = 0;
  int fbm [0:69][0:3];
  int fal [0:69][0:7];
  int mu [0:1][0:69];
  int mp [0:1][0:69];

  function automatic int clampi(input int s);
    return (s > POS) ? POS : (s < NEG) ? NEG : s;
  endfunction
  function automatic int sat_add(input int a, input int b);
    return (a == NEG || b == NEG) ? NEG : clampi(a + b);
  endfunction
  function automatic int par(input int x);
    return ($countones(x) & 1);
  endfunction
  function automatic int m_llr(input int m1, input int m0);
    int d;
    if (m1 == NEG) return -LM;
    if (m0 == NEG) return LM;
    d = m1 - m0;
    return (d > LM) ? LM : (d < -LM) ? -LM : d;
  endfunction

  task automatic model(input int n, input int term);
    int beta [0:7];
    int bn [0:7];
    int a, p, nx, cur, om, m1u, m0u, m1p, m0p, mx;
    for (int s = 0; s < ST; s++) beta[s] = (term != 0 && s != 0) ? NEG : 0;
    for (int k = n - 1; k >= 0; k--) begin
      m1u = NEG; m0u = NEG; m1p = NEG; m0p = NEG;
      for (int s = 0; s < ST; s++) begin
        bn[s] = NEG;
        for (int u = 0; u < 2; u++) begin
          a   = u ^ par(s & FBM);
          p   = (FFTOP & a) ^ par(s & FFM);
          nx  = ((s << 1) | a) & (ST - 1);
          cur = sat_add(beta[nx], fbm[k][2*u + p]);
          if (cur > bn[s]) bn[s] = cur;
          om = sat_add(cur, fal[k][s]);
          if (u == 1) begin if (om > m1u) m1u = om; end else begin if (om > m0u) m0u = om; end
          if (p == 1) begin if (om > m1p) m1p = om; end else begin if (om > m0p) m0p = om; end
        end
      end
      mu[term][k] = m_llr(m1u, m0u);
      mp[term][k] = m_llr(m1p, m0p);
      mx = NEG;
      for (int s = 0; s < ST; s++) if (bn[s] > mx) mx = bn[s];
      for (int s = 0; s < ST; s++) beta[s] = (bn[s] == NEG) ? NEG : clampi(bn[s] - mx);
    end
  endtask

  task automatic push_model(input int n);
    exp_t e;
    model(n, 0);
    model(n, 1);
    for (int k = n - 1; k >= 0; k--) begin
      e.idx = k;
      e.lt = {10'(mp[1][k]), 10'(mu[1][k])};
      e.lo = {10'(mp[0][k]), 10'(mu[0][k])};
      e.last = (k == 0);
      sb.push_back(e);
    end
  endtask

  task automatic push_fixed(input int tu, input int tp, input int ou, input int op);
    exp_t e;
    e.idx = 0; e.lt = {10'(tp), 10'(tu)}; e.lo = {10'(op), 10'(ou)}; e.last = 1'b1;
    sb.push_back(e);
  endtask

  task automatic gen_random(input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 4; i++)  fbm[b][i] = int'($urandom_range(400)) - 200;
      for (int s = 0; s < ST; s++) fal[b][s] = int'($urandom_range(400)) - 200;
    end
  endtask

  task automatic drive_frame(input int n);
    int b = 0, wait_c = 0;
    logic rdy;
    while (b < n) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = (b == n - 1);
      for (int i = 0; i < 4; i++)  in_bm[i*MW +: MW]    = 12'(fbm[b][i]);
      for (int s = 0; s < ST; s++) in_alpha[s*MW +: MW] = 12'(fal[b][s]);
      rdy = in_ready_t;
      @(posedge clk);
      if (rdy) begin
        b++;
        wait_c = 0;
        if (b == n) #1 last_in_cyc = cyc;
      end else if (++wait_c > 300) begin
        n_checks++; n_fail++;
        $display("FAIL drive_timeout: beat %0d of %0d not accepted within 300 cycles", b, n);
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: out_ready cycles 1,0,0,1.
  task automatic collect(input int n_exp, input int mode);
    int got = 0, idle = 0, ph = 0, prev_c = -1;
    logic held = 1'b0;
    logic [19:0] h_llr;
    logic [5:0] h_idx;
    exp_t e;
    while (got < n_exp) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((ph % 4) == 0 || (ph % 4) == 3);
      ph++;
      if (out_valid_t) begin
        idle = 0;
        if (held) begin
          n_checks++;
          if (out_llr_t !== h_llr || out_index_t !== h_idx) begin
            n_fail++;
            $display("FAIL stall_hold: got idx %0d llr %h, held idx %0d llr %h", out_index_t, out_llr_t, h_idx, h_llr);
          end
        end
        n_checks++;
        if (out_valid_o !== 1'b1 || out_index_o !== out_index_t) begin
          n_fail++;
          $display("FAIL open_align: open valid %b idx %0d, need 1 idx %0d", out_valid_o, out_index_o, out_index_t);
        end
        if (out_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL extra_output: idx %0d with empty scoreboard, need none", out_index_t);
          end else begin
            e = sb.pop_front();
            if (out_index_t !== 6'(e.idx) || out_last_t !== e.last) begin
              n_fail++;
              $display("FAIL index: got idx %0d last %b, need idx %0d last %b", out_index_t, out_last_t, e.idx, e.last);
            end
            n_checks++;
            if (out_llr_t !== e.lt) begin
              n_fail++;
              $display("FAIL llr_term idx %0d: got %h, need %h", e.idx, out_llr_t, e.lt);
            end
            n_checks++;
            if (out_llr_o !== e.lo) begin
              n_fail++;
              $display("FAIL llr_open idx %0d: got %h, need %h", e.idx, out_llr_o, e.lo);
            end
            if (mode == 0) begin
              n_checks++;
              if ((prev_c < 0 && cyc != last_in_cyc + 1) || (prev_c >= 0 && cyc != prev_c + 1)) begin
                n_fail++;
                $display("FAIL timing idx %0d: got cycle %0d, need %0d", e.idx, cyc,
                         (prev_c < 0) ? last_in_cyc + 1 : prev_c + 1);
              end
              prev_c = e.last ? -1 : cyc;
            end
          end
          got++;
          held = 1'b0;
        end else begin
          held  = 1'b1;
          h_llr = out_llr_t;
          h_idx = out_index_t;
        end
      end else if (++idle > 300) begin
        n_checks++; n_fail++;
        $display("FAIL collect_timeout: got %0d outputs, need %0d", got, n_exp);
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic check_empty(input string name);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected outputs left, need 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready_t, out_valid_t, out_last_t, overflow_t, out_valid_o} !== 5'b0 ||
        out_llr_t !== '0 || out_index_t !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy %b vld %b last %b ovf %b llr %h idx %0d, need all 0",
               in_ready_t, out_valid_t, out_last_t, overflow_t, out_llr_t, out_index_t);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready_t !== 1'b0) begin
      n_fail++; $display("FAIL idle_ready: got %b, need 0", in_ready_t);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready_t !== 1'b1) begin
      n_fail++; $display("FAIL load_ready: got %b, need 1", in_ready_t);
    end
  endtask

  task automatic test_single(input int b3, input int tu, input int tp, input int ou, input int op);
    fbm[0][0] = 10; fbm[0][1] = 0; fbm[0][2] = 0; fbm[0][3] = b3;
    for (int s = 0; s < ST; s++) fal[0][s] = 0;
    push_fixed(tu, tp, ou, op);
    fork
      drive_frame(1);
      collect(1, 0);
    join
    check_empty("single");
  endtask

  task automatic test_frame(input int n, input int mode);
    push_model(n);
    fork
      drive_frame(n);
      collect(n, mode);
    join
    check_empty(mode == 0 ? "frame" : "backpressure");
  endtask

  task automatic test_back_to_back();
    gen_random(3);
    push_model(3);
    fork
      begin
        drive_frame(3);
        gen_random(2);
        push_model(2);
        drive_frame(2);
      end
      collect(5, 0);
    join
    check_empty("back_to_back");
  endtask

  task automatic test_overflow();
    gen_random(MS + 2);
    push_model(MS);
    fork
      drive_frame(MS + 2);
      collect(MS, 0);
    join
    check_empty("overflow_count");
    @(negedge clk);
    n_checks++;
    if (overflow_t !== 1'b1 || overflow_o !== 1'b1 || in_ready_t !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: ovf %b/%b rdy %b, need 1/1 1", overflow_t, overflow_o, in_ready_t);
    end
  endtask

  task automatic test_reset_midrun();
    int w = 0;
    out_ready = 1'b0;
    gen_random(8);
    drive_frame(8);
    while (out_valid_t !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (out_valid_t !== 1'b1) begin
      n_fail++; $display("FAIL midrun_start: out_valid %b, need 1", out_valid_t);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid_t !== 1'b0 || out_valid_o !== 1'b0 || overflow_t !== 1'b0 || in_ready_t !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: vld %b/%b ovf %b rdy %b, need 0/0 0 0", out_valid_t, out_valid_o, overflow_t, in_ready_t);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    gen_random(2);
    test_frame(2, 0);
  endtask

  initial begin
    test_reset();
    test_single(6, -LM, -10, -4, -4);
    test_single(0, -LM, -10, -10, -10);
    gen_random(4);
    test_frame(4, 0);
    test_frame(4, 1);
    test_back_to_back();
    test_overflow();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
